pipe_stage: RTL

Parametrised pipeline stage register that generalises the fixed inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) into one reusable block. It carries a DATA_W-bit payload plus a CTRL_W-bit control bundle, and uses a valid/ready handshake with a 2-entry skid buffer so back-pressure never loses data. It also supports synchronous flush with bubble insertion and a saturating stall-cycle counter. It sits between any two CPU pipeline stages; the hazard unit drives `flush_i` and the downstream `out_ready_i`.

---
 rtl/pipe_pkg.sv | 57 +++++
 rtl/pipe_stage_sat_counter.sv | 23 ++
 rtl/pipe_stage.sv | 133 +++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: handshake stage states, the NOP control bundle
// and the packed inter-stage payload layouts that size each pipe_stage instance.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam int    CTRL_W_PIPE = $bits(ctrl_t);
  // Every write enable and memory strobe off: safe to inject as a bubble.
  localparam ctrl_t CTRL_NOP    = '0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [63:0] rsvd;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_res;
    logic [31:0] store_val;
    logic [4:0]  rd;
    logic [26:0] rsvd;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_res;
    logic [31:0] load_val;
    logic [4:0]  rd;
    logic [26:0] rsvd;
  } mem_wb_t;

  localparam int DATA_W_PIPE = $bits(id_ex_t);

endpackage

// File: rtl/pipe_stage_sat_counter.sv
// Saturating up-counter with asynchronous active-low reset; holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/pipe_stage.sv
// Reusable pipeline stage register: valid/ready handshake with a 2-entry skid
// buffer, flush with bubble insertion and a saturating stall-cycle counter.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = 128,
  parameter int                CTRL_W      = 9,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
  parameter int                CNT_W       = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  state_t            r_state;
  logic              r_out_valid;
  logic              r_in_ready;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;

  state_t            w_next;
  logic              w_accept;
  logic              w_emit;
  logic              w_ld_main_in;
  logic              w_ld_skid_in;
  logic              w_ld_main_skid;
  logic              w_stall;

  assign w_accept = in_valid_i & r_in_ready;
  assign w_emit   = r_out_valid & out_ready_i;
  assign w_stall  = r_out_valid & ~out_ready_i;

  always_comb begin
    w_next         = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_skid_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    if (flush_i) begin
      // Held words die here; any accept this cycle is dropped on the floor.
      w_next = EMPTY;
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_accept) begin
            w_next       = ONE;
            w_ld_main_in = 1'b1;
          end
        end
        ONE: begin
          if (w_accept && w_emit) begin
            w_ld_main_in = 1'b1;
          end else if (w_accept) begin
            w_next       = FULL;
            w_ld_skid_in = 1'b1;
          end else if (w_emit) begin
            w_next = EMPTY;
          end
        end
        FULL: begin
          if (w_emit) begin
            w_next         = ONE;
            w_ld_main_skid = 1'b1;
          end
        end
        default: w_next = EMPTY;
      endcase
    end
  end

  // Control state: valid and ready are precomputed from the next state so both
  // leave the block straight from flops.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_state     <= w_next;
      r_out_valid <= (w_next != EMPTY);
      r_in_ready  <= (w_next != FULL);
    end
  end

  // Payload and control storage; flush leaves contents untouched.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_main_data <= '0;
      r_main_ctrl <= CTRL_BUBBLE;
      r_skid_data <= '0;
      r_skid_ctrl <= CTRL_BUBBLE;
    end else begin
      if (w_ld_main_in) begin
        r_main_data <= in_data_i;
        r_main_ctrl <= in_ctrl_i;
      end else if (w_ld_main_skid) begin
        r_main_data <= r_skid_data;
        r_main_ctrl <= r_skid_ctrl;
      end
      if (w_ld_skid_in) begin
        r_skid_data <= in_data_i;
        r_skid_ctrl <= in_ctrl_i;
      end
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (w_stall),
    .cnt_o   (stall_cnt_o)
  );

  assign in_ready_o  = r_in_ready;
  assign out_valid_o = r_out_valid;
  assign out_data_o  = r_main_data;
  // Bubble mux sits on the narrow control bundle only, fed purely by flops.
  assign out_ctrl_o  = r_out_valid ? r_main_ctrl : CTRL_BUBBLE;

endmodule
